// File: rtl/key_cmd_queue.sv
// key_cmd_queue: keypad code synchronizer, hold qualifier, command mapper and 4-entry FWFT command FIFO.
// Optional feature macro: KEY_CMD_REPEAT_EN (auto-repeat of held direction keys).
module key_cmd_queue #(
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 7500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_down,
  input  logic [3:0] key_value,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  output logic       cmd_drop,
  output logic       key_held
);
  typedef enum logic [1:0] {IDLE, QUAL, HELD} state_t;

  localparam logic [19:0] STABLE_LAST = 20'(STABLE_CYCLES - 1);

  state_t      state;
  logic        down_meta, key_down_s;
  logic [3:0]  key_meta, key_s, code;
  logic [19:0] stab_cnt;
  logic [2:0]  mem [4];
  logic [1:0]  rd_ptr, wr_ptr;
  logic [2:0]  count;
  logic        map_valid;
  logic [2:0]  map_cmd;
  logic        same_key, press_fire, ev, pop, push, full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      down_meta  <= 1'b0;
      key_down_s <= 1'b0;
      key_meta   <= '0;
      key_s      <= '0;
    end else begin
      down_meta  <= key_down;
      key_down_s <= down_meta;
      key_meta   <= key_value;
      key_s      <= key_meta;
    end
  end

  always_comb begin
    map_valid = 1'b1;
    map_cmd   = 3'd0;
    case (code)
      4'd1:    map_cmd = 3'd0;
      4'd9:    map_cmd = 3'd1;
      4'd4:    map_cmd = 3'd2;
      4'd6:    map_cmd = 3'd3;
      4'd5:    map_cmd = 3'd4;
      4'd15:   map_cmd = 3'd5;
      default: map_valid = 1'b0;
    endcase
  end

  assign same_key   = key_down_s && (key_s == code);
  assign press_fire = (state == QUAL) && same_key && (stab_cnt == STABLE_LAST);

`ifdef KEY_CMD_REPEAT_EN
  localparam logic [24:0] DELAY_LAST  = 25'(REPEAT_DELAY - 1);
  localparam logic [24:0] PERIOD_LAST = 25'(REPEAT_PERIOD - 1);

  logic [24:0] rep_cnt;
  logic        rep_first, rep_due, rep_fire;

  // rep_first selects the initial delay until the first repeat has fired
  assign rep_due  = rep_cnt == (rep_first ? DELAY_LAST : PERIOD_LAST);
  assign rep_fire = (state == HELD) && same_key && rep_due && !map_cmd[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (press_fire) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if ((state == HELD) && same_key) begin
      if (rep_due) begin
        rep_cnt   <= '0;
        rep_first <= 1'b0;
      end else begin
        rep_cnt <= rep_cnt + 25'd1;
      end
    end
  end

  assign ev = map_valid && (press_fire || rep_fire);
`else
  assign ev = map_valid && press_fire;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      code     <= '0;
      stab_cnt <= '0;
      key_held <= 1'b0;
    end else begin
      case (state)
        IDLE: if (key_down_s) begin
          code     <= key_s;
          stab_cnt <= '0;
          state    <= QUAL;
        end
        QUAL: begin
          if (!key_down_s) begin
            state <= IDLE;
          end else if (key_s != code) begin
            code     <= key_s;
            stab_cnt <= '0;
          end else if (press_fire) begin
            state    <= HELD;
            key_held <= 1'b1;
          end else begin
            stab_cnt <= stab_cnt + 20'd1;
          end
        end
        HELD: begin
          if (!key_down_s) begin
            state    <= IDLE;
            key_held <= 1'b0;
          end else if (key_s != code) begin
            code     <= key_s;
            stab_cnt <= '0;
            state    <= QUAL;
            key_held <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign full      = count == 3'd4;
  assign cmd_valid = count != 3'd0;
  assign cmd       = mem[rd_ptr];
  assign pop       = cmd_valid && cmd_ready;
  // a pop on a full FIFO frees the slot the write pointer already points at
  assign push      = ev && (!full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      cmd_drop <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      cmd_drop <= ev && full && !pop;
      if (push) begin
        mem[wr_ptr] <= map_cmd;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: doc/key_cmd_queue.md
# key_cmd_queue

Converts the 4x4 keypad scanner's raw key code into qualified maze-game commands. The block:
- synchronizes the scanner outputs;
- requires a key to be held stable before accepting it;
- maps accepted keys to command codes, with optional auto-repeat for held direction keys;
- buffers commands in a 4-entry FIFO with a valid/ready handshake toward the maze game logic.

It sits directly downstream of the keypad scanner.

## Interface
Parameters:
- STABLE_CYCLES, 500000: consecutive cycles a key must be held unchanged before it is accepted (10 ms at 50 MHz); legal range 1 to 2^20-1.
- REPEAT_DELAY, 25000000: cycles from the initial press event to the first repeat; legal range 1 to 2^25-1.
- REPEAT_PERIOD, 7500000: cycles between subsequent repeats; legal range 1 to 2^25-1.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- key_down  input  1  scanner key flag; 1 while a key is held.
- key_value  input  4  scanner key code 0-15; only meaningful while key_down=1, ignored otherwise.
- cmd_ready  input  1  consumer accepts the head entry this cycle.
- cmd_valid  output  1  FIFO is non-empty.
- cmd  output  3  head command. Codes: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 ACTION, 5 RESTART.
- cmd_drop  output  1  one-cycle pulse when an event is lost because the FIFO is full.
- key_held  output  1  high while the FSM is in HELD.

## Operation
Input path:
- key_down and key_value each pass through a 2-flop synchronizer; the synchronized versions are key_down_s and key_s.
- The FSM reads only key_down_s and key_s.

FSM states:
- IDLE
  - If key_down_s=1: latch code←key_s, stable counter←0, go to QUAL.
- QUAL
  - If key_down_s=0: go to IDLE.
  - Else if key_s≠code: relatch code←key_s, counter←0, stay in QUAL.
  - Else if counter=STABLE_CYCLES-1: emit the press event, clear the repeat counter, go to HELD.
  - Else: counter+1.
- HELD
  - If key_down_s=0: go to IDLE.
  - Else if key_s≠code: relatch code←key_s, counter←0, go to QUAL.
  - Else: advance the repeat counter (see Configuration).

Key mapping:
- key 1→UP, 9→DOWN, 4→LEFT, 6→RIGHT, 5→ACTION, 15→RESTART.
- All other codes are unmapped: the FSM still qualifies them and enters HELD, but nothing is pushed.

FIFO:
- 4 entries, first-word-fall-through; an internal occupancy count runs 0-4.
- A pop occurs when cmd_valid and cmd_ready are both high.
- A push occurs when an event is mapped and either count<4, or count=4 with a pop in the same cycle.
- Push and pop in the same cycle: count is unchanged and ordering is preserved.
- Event while full with no pop: the event is dropped, cmd_drop pulses, and FIFO contents are unchanged.
- cmd_ready while empty has no effect.
- Read and write pointers are 2-bit and wrap 3→0.

Reset:
- Clears the synchronizers, FSM (to IDLE), all counters, FIFO pointers and count.
- All outputs are 0 during and after reset.
- A reset asserted mid-hold or mid-qualification discards the partial press. After release, the block requires a fresh qualification, even if the key is still down.

## Timing
- Edge 1 is the first clk edge at which key_down=1 with a mapped key_value.
- Press latency: the event is pushed at edge STABLE_CYCLES+3, and cmd_valid is high after that edge.
- Any release or code change during QUAL restarts qualification.
- The event is pushed on the same edge as the QUAL→HELD transition.
- key_held rises at that same edge and falls 3 edges after key_down falls (2 synchronizer edges plus 1 FSM edge).
- FIFO handshake: cmd and cmd_valid change only on clk edges. cmd shows the new head on the edge after a pop.
- cmd_drop is high for exactly one cycle, after the edge on which the event was dropped.

## Configuration
- KEY_CMD_REPEAT_EN defined:
  - Auto-repeat applies to UP, DOWN, LEFT and RIGHT only; ACTION and RESTART never repeat.
  - With the press event at edge E and the key held unchanged, repeat events occur at E+REPEAT_DELAY, then every REPEAT_PERIOD edges.
  - Repeat events follow the same push/drop rules as the initial press.
  - Leaving HELD stops repeats immediately.
- KEY_CMD_REPEAT_EN undefined:
  - The repeat counter and its logic are absent.
  - Exactly one event is produced per qualified press.

## Test plan
All scenarios use STABLE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- Reset, then hold key 6 with cmd_ready=0 → cmd_valid rises after edge 7 with cmd=3; key_held=1; cmd_drop never pulses.
- Key 9 held 3 cycles, released, then held 10 cycles → only one DOWN (cmd=1) is produced, timed from the second press.
- With KEY_CMD_REPEAT_EN, hold key 1 for 50 edges, cmd_ready=1 → UP events at E, E+20, E+28, E+36, E+44; hold key 5 for 50 edges → a single ACTION.
- Without KEY_CMD_REPEAT_EN, hold key 1 for 50 edges → a single UP event.
- cmd_ready=0, five separate presses 1,9,4,6,5 → FIFO holds UP,DOWN,LEFT,RIGHT; the fifth press gives one cmd_drop pulse. Then assert cmd_ready → pops 0,1,2,3 in order, then cmd_valid=0.
- Assert reset mid-QUAL and again mid-HELD with key 4 held → outputs 0 immediately; after reset release, LEFT appears after a fresh STABLE_CYCLES+3 edges.
